// File: rtl/mem_pkg.sv
// Shared defaults and helpers for the memory access front end.
package mem_pkg;

  localparam int unsigned MemWidth  = 12;
  localparam int unsigned AddrWidth = 12;
  localparam int unsigned PortCount = 2;

  // Bits needed to hold an index in 0..n-1; never less than one bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/rr_grant_select.sv
// Rotating-priority picker: starting at the pointer, takes up to port_count
// valid requests, skipping any that would hit an already-picked address
// where either side writes. Purely combinational.
module rr_grant_select #(
  parameter int unsigned req_count  = 4,
  parameter int unsigned port_count = 2,
  parameter int unsigned addr_width = 12,
  parameter int unsigned id_width   = 2
) (
  input  logic                             enable_i,
  input  logic [req_count-1:0]             req_valid_i,
  input  logic [req_count-1:0]             req_write_i,
  input  logic [req_count*addr_width-1:0]  req_addr_i,
  input  logic [id_width-1:0]              rr_ptr_i,
  output logic [req_count-1:0]             req_ready_o,
  output logic [port_count-1:0]            port_valid_o,
  output logic [port_count*id_width-1:0]   port_idx_o,
  output logic [id_width-1:0]              next_ptr_o
);

  logic [addr_width-1:0] sel_addr  [port_count];
  logic                  sel_write [port_count];
  logic [addr_width-1:0] cand_addr;
  logic                  hazard;
  int unsigned           idx;
  int unsigned           n_sel;

  // Scan clients in rotated order, filling ports in scan order.
  always_comb begin
    req_ready_o  = '0;
    port_valid_o = '0;
    port_idx_o   = '0;
    next_ptr_o   = rr_ptr_i;
    n_sel        = 0;
    idx          = 0;
    hazard       = 1'b0;
    cand_addr    = '0;
    for (int unsigned p = 0; p < port_count; p++) begin
      sel_addr[p]  = '0;
      sel_write[p] = 1'b0;
    end
    for (int unsigned off = 0; off < req_count; off++) begin
      idx = 32'(rr_ptr_i) + off;
      if (idx >= req_count) idx = idx - req_count;
      cand_addr = req_addr_i[idx*addr_width +: addr_width];
      hazard    = 1'b0;
      for (int unsigned p = 0; p < port_count; p++) begin
        if (p < n_sel && sel_addr[p] == cand_addr && (sel_write[p] || req_write_i[idx])) begin
          hazard = 1'b1;
        end
      end
      if (enable_i && req_valid_i[idx] && !hazard && n_sel < port_count) begin
        req_ready_o[idx] = 1'b1;
        for (int unsigned p = 0; p < port_count; p++) begin
          if (p == n_sel) begin
            port_valid_o[p]                       = 1'b1;
            port_idx_o[p*id_width +: id_width]    = id_width'(idx);
            sel_addr[p]                           = cand_addr;
            sel_write[p]                          = req_write_i[idx];
          end
        end
        next_ptr_o = (idx + 1 == req_count) ? '0 : id_width'(idx + 1);
        n_sel      = n_sel + 1;
      end
    end
  end

endmodule

// File: rtl/mem_access_arbiter.sv
// Request scheduler in front of the multiport RAM: grants clients onto RAM
// ports, drives the packed RAM buses and routes registered read data back.
module mem_access_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned req_count  = 4,
  parameter int unsigned port_count = PortCount,
  parameter int unsigned mem_width  = MemWidth,
  parameter int unsigned addr_width = AddrWidth
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [req_count-1:0]             req_valid,
  output logic [req_count-1:0]             req_ready,
  input  logic [req_count-1:0]             req_write,
  input  logic [req_count*addr_width-1:0]  req_addr,
  input  logic [req_count*mem_width-1:0]   req_wdata,
  output logic [req_count-1:0]             resp_valid,
  output logic [req_count*mem_width-1:0]   resp_data,
  output logic [port_count*addr_width-1:0] mem_address,
  output logic [port_count*mem_width-1:0]  mem_datain,
  output logic [port_count-1:0]            mem_write,
  input  logic [port_count*mem_width-1:0]  mem_dataout
);

  localparam int unsigned IdWidth = clog2(req_count);

  logic [IdWidth-1:0]            rr_ptr_q, rr_ptr_d;
  logic [port_count-1:0]         tag_valid_q, tag_valid_d;
  logic [port_count*IdWidth-1:0] tag_id_q, tag_id_d;
  logic [req_count*mem_width-1:0] resp_data_q, resp_data_d;

  logic [port_count-1:0]         port_valid;
  logic [port_count*IdWidth-1:0] port_idx;
  logic [IdWidth-1:0]            next_ptr;
  int unsigned                   cid;

  // Grants are suppressed while reset is asserted.
  rr_grant_select #(
    .req_count  (req_count),
    .port_count (port_count),
    .addr_width (addr_width),
    .id_width   (IdWidth)
  ) u_select (
    .enable_i     (reset_n),
    .req_valid_i  (req_valid),
    .req_write_i  (req_write),
    .req_addr_i   (req_addr),
    .rr_ptr_i     (rr_ptr_q),
    .req_ready_o  (req_ready),
    .port_valid_o (port_valid),
    .port_idx_o   (port_idx),
    .next_ptr_o   (next_ptr)
  );

  // Drive RAM ports from the granted clients; idle ports stay all-zero.
  always_comb begin
    mem_address = '0;
    mem_datain  = '0;
    mem_write   = '0;
    cid         = 0;
    for (int unsigned p = 0; p < port_count; p++) begin
      if (port_valid[p]) begin
        cid = 32'(port_idx[p*IdWidth +: IdWidth]);
        mem_address[p*addr_width +: addr_width] = req_addr[cid*addr_width +: addr_width];
        mem_datain[p*mem_width +: mem_width]    = req_wdata[cid*mem_width +: mem_width];
        mem_write[p]                            = req_write[cid];
      end
    end
  end

  // Route last cycle's tags to clients; data slices hold when not responding.
  always_comb begin
    resp_valid = '0;
    resp_data  = resp_data_q;
    for (int unsigned p = 0; p < port_count; p++) begin
      if (tag_valid_q[p]) begin
        for (int unsigned c = 0; c < req_count; c++) begin
          if (tag_id_q[p*IdWidth +: IdWidth] == IdWidth'(c)) begin
            resp_valid[c]                      = 1'b1;
            resp_data[c*mem_width +: mem_width] = mem_dataout[p*mem_width +: mem_width];
          end
        end
      end
    end
  end

  // Next-state for pointer, tags and held response data.
  always_comb begin
    rr_ptr_d    = (|port_valid) ? next_ptr : rr_ptr_q;
    tag_valid_d = port_valid;
    tag_id_d    = port_idx;
    resp_data_d = resp_data;
  end

  // State registers; reset drops any in-flight tags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q    <= '0;
      tag_valid_q <= '0;
      tag_id_q    <= '0;
      resp_data_q <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      tag_valid_q <= tag_valid_d;
      tag_id_q    <= tag_id_d;
      resp_data_q <= resp_data_d;
    end
  end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed bench for mem_access_arbiter with a write-first registered RAM model.
module tb_mem_access_arbiter;

  logic        clk;
  logic        reset_n;
  logic [3:0]  req_valid, req_ready, req_write, resp_valid;
  logic [47:0] req_addr, req_wdata, resp_data;
  logic [23:0] mem_address, mem_datain, mem_dataout;
  logic [1:0]  mem_write;

  int n_chk;
  int n_fail;

  mem_access_arbiter #(
    .req_count  (4),
    .port_count (2),
    .mem_width  (12),
    .addr_width (12)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_data   (resp_data),
    .mem_address (mem_address),
    .mem_datain  (mem_datain),
    .mem_write   (mem_write),
    .mem_dataout (mem_dataout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Two-port RAM: registered output, write-first.
  logic [11:0] ram [4096];
  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = '0;
    mem_dataout = '0;
  end
  always @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (mem_write[p]) begin
        ram[mem_address[p*12 +: 12]] <= mem_datain[p*12 +: 12];
        mem_dataout[p*12 +: 12]      <= mem_datain[p*12 +: 12];
      end else begin
        mem_dataout[p*12 +: 12] <= ram[mem_address[p*12 +: 12]];
      end
    end
  end

  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  write;
    logic [47:0] addr;
    logic [47:0] wdata;
    logic [3:0]  ready;
    logic [1:0]  mw;
    logic [23:0] maddr;
    logic [23:0] mdin;
    logic [3:0]  rv;
    logic [3:0]  chk;
    logic [47:0] rdata;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [3:0] v, input logic [3:0] w, input logic [47:0] a,
                              input logic [47:0] d, input logic [3:0] rdy, input logic [1:0] mw,
                              input logic [23:0] ma, input logic [23:0] md, input logic [3:0] rv,
                              input logic [3:0] ck, input logic [47:0] rd);
    vec_t t;
    t.valid = v; t.write = w; t.addr = a; t.wdata = d; t.ready = rdy; t.mw = mw;
    t.maddr = ma; t.mdin = md; t.rv = rv; t.chk = ck; t.rdata = rd;
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] v, input logic [3:0] w, input logic [47:0] a,
                       input logic [47:0] d);
    req_valid = v; req_write = w; req_addr = a; req_wdata = d;
  endtask

  task automatic chk_resp(input string tag, input logic [3:0] rv, input logic [3:0] ck,
                          input logic [47:0] rd);
    chk({tag, " resp_valid"}, 64'(resp_valid), 64'(rv));
    for (int c = 0; c < 4; c++) begin
      if (ck[c]) chk($sformatf("%s resp_data[%0d]", tag, c), 64'(resp_data[c*12 +: 12]),
                     64'(rd[c*12 +: 12]));
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;

    // Request lines active during reset must not be granted.
    reset_n = 1'b0;
    drive(4'hF, 4'hF, {12'h3, 12'h2, 12'h1, 12'h0}, 48'h0);
    #2;
    chk("reset req_ready", 64'(req_ready), 64'h0);
    chk("reset mem_write", 64'(mem_write), 64'h0);
    chk("reset mem_address", 64'(mem_address), 64'h0);
    chk("reset resp_valid", 64'(resp_valid), 64'h0);
    chk("reset resp_data", 64'(resp_data), 64'h0);
    drive(4'h0, 4'h0, 48'h0, 48'h0);
    #1 reset_n = 1'b1;

    // valid write addr wdata | ready mw maddr mdin | rv chk rdata
    vecs.push_back(mk(4'b0000, 4'b0000, 48'h0, 48'h0, 4'b0000, 2'b00, 24'h0, 24'h0,
                      4'b0000, 4'b0000, 48'h0));
    // single store, client 0
    vecs.push_back(mk(4'b0001, 4'b0001, {36'h0, 12'h010}, {36'h0, 12'hABC}, 4'b0001, 2'b01,
                      {12'h0, 12'h010}, {12'h0, 12'hABC}, 4'b0000, 4'b0000, 48'h0));
    vecs.push_back(mk(4'b0000, 4'b0000, 48'h0, 48'h0, 4'b0000, 2'b00, 24'h0, 24'h0,
                      4'b0001, 4'b0001, {36'h0, 12'hABC}));
    // store then load, client 1
    vecs.push_back(mk(4'b0010, 4'b0010, {24'h0, 12'h020, 12'h0}, {24'h0, 12'h123, 12'h0},
                      4'b0010, 2'b01, {12'h0, 12'h020}, {12'h0, 12'h123}, 4'b0000, 4'b0000, 48'h0));
    vecs.push_back(mk(4'b0010, 4'b0000, {24'h0, 12'h020, 12'h0}, 48'h0, 4'b0010, 2'b00,
                      {12'h0, 12'h020}, 24'h0, 4'b0010, 4'b0010, {24'h0, 12'h123, 12'h0}));
    vecs.push_back(mk(4'b0000, 4'b0000, 48'h0, 48'h0, 4'b0000, 2'b00, 24'h0, 24'h0,
                      4'b0010, 4'b0010, {24'h0, 12'h123, 12'h0}));
    // fairness: pointer is at 2, so pairs alternate {2,3},{0,1}
    vecs.push_back(mk(4'hF, 4'h0, {12'h103, 12'h102, 12'h101, 12'h100}, 48'h0, 4'b1100, 2'b00,
                      {12'h103, 12'h102}, 24'h0, 4'b0000, 4'b0000, 48'h0));
    vecs.push_back(mk(4'hF, 4'h0, {12'h103, 12'h102, 12'h101, 12'h100}, 48'h0, 4'b0011, 2'b00,
                      {12'h101, 12'h100}, 24'h0, 4'b1100, 4'b1100, 48'h0));
    vecs.push_back(mk(4'hF, 4'h0, {12'h103, 12'h102, 12'h101, 12'h100}, 48'h0, 4'b1100, 2'b00,
                      {12'h103, 12'h102}, 24'h0, 4'b0011, 4'b0011, 48'h0));
    vecs.push_back(mk(4'hF, 4'h0, {12'h103, 12'h102, 12'h101, 12'h100}, 48'h0, 4'b0011, 2'b00,
                      {12'h101, 12'h100}, 24'h0, 4'b1100, 4'b1100, 48'h0));
    vecs.push_back(mk(4'b0000, 4'b0000, 48'h0, 48'h0, 4'b0000, 2'b00, 24'h0, 24'h0,
                      4'b0011, 4'b0011, 48'h0));
    // write conflict on 0x040: client 0 first, client 1 waits
    vecs.push_back(mk(4'b0011, 4'b0011, {24'h0, 12'h040, 12'h040}, {24'h0, 12'h222, 12'h111},
                      4'b0001, 2'b01, {12'h0, 12'h040}, {12'h0, 12'h111}, 4'b0000, 4'b0000, 48'h0));
    vecs.push_back(mk(4'b0010, 4'b0010, {24'h0, 12'h040, 12'h0}, {24'h0, 12'h222, 12'h0},
                      4'b0010, 2'b01, {12'h0, 12'h040}, {12'h0, 12'h222},
                      4'b0001, 4'b0001, {36'h0, 12'h111}));
    vecs.push_back(mk(4'b0001, 4'b0000, {36'h0, 12'h040}, 48'h0, 4'b0001, 2'b00,
                      {12'h0, 12'h040}, 24'h0, 4'b0010, 4'b0010, {24'h0, 12'h222, 12'h0}));
    vecs.push_back(mk(4'b0000, 4'b0000, 48'h0, 48'h0, 4'b0000, 2'b00, 24'h0, 24'h0,
                      4'b0001, 4'b0001, {36'h0, 12'h222}));
    // read sharing on 0x050
    vecs.push_back(mk(4'b0100, 4'b0100, {12'h0, 12'h050, 24'h0}, {12'h0, 12'h5A5, 24'h0},
                      4'b0100, 2'b01, {12'h0, 12'h050}, {12'h0, 12'h5A5}, 4'b0000, 4'b0000, 48'h0));
    vecs.push_back(mk(4'b1100, 4'b0000, {12'h050, 12'h050, 24'h0}, 48'h0, 4'b1100, 2'b00,
                      {12'h050, 12'h050}, 24'h0, 4'b0100, 4'b0100, {12'h0, 12'h5A5, 24'h0}));
    vecs.push_back(mk(4'b0000, 4'b0000, 48'h0, 48'h0, 4'b0000, 2'b00, 24'h0, 24'h0,
                      4'b1100, 4'b1100, {12'h5A5, 12'h5A5, 24'h0}));
    // read vs write on same address: the write waits
    vecs.push_back(mk(4'b0011, 4'b0010, {24'h0, 12'h050, 12'h050}, {24'h0, 12'h777, 12'h0},
                      4'b0001, 2'b00, {12'h0, 12'h050}, 24'h0, 4'b0000, 4'b0000, 48'h0));
    vecs.push_back(mk(4'b0010, 4'b0010, {24'h0, 12'h050, 12'h0}, {24'h0, 12'h777, 12'h0},
                      4'b0010, 2'b01, {12'h0, 12'h050}, {12'h0, 12'h777},
                      4'b0001, 4'b0001, {36'h0, 12'h5A5}));
    vecs.push_back(mk(4'b0000, 4'b0000, 48'h0, 48'h0, 4'b0000, 2'b00, 24'h0, 24'h0,
                      4'b0010, 4'b0010, {24'h0, 12'h777, 12'h0}));
    // response data holds when idle
    vecs.push_back(mk(4'b0000, 4'b0000, 48'h0, 48'h0, 4'b0000, 2'b00, 24'h0, 24'h0,
                      4'b0000, 4'b0011, {24'h0, 12'h777, 12'h5A5}));

    foreach (vecs[i]) begin
      @(posedge clk);
      #1 drive(vecs[i].valid, vecs[i].write, vecs[i].addr, vecs[i].wdata);
      #3;
      chk($sformatf("v%0d req_ready", i), 64'(req_ready), 64'(vecs[i].ready));
      chk($sformatf("v%0d mem_write", i), 64'(mem_write), 64'(vecs[i].mw));
      chk($sformatf("v%0d mem_address", i), 64'(mem_address), 64'(vecs[i].maddr));
      chk($sformatf("v%0d mem_datain", i), 64'(mem_datain), 64'(vecs[i].mdin));
      chk_resp($sformatf("v%0d", i), vecs[i].rv, vecs[i].chk, vecs[i].rdata);
    end

    // Reset in the middle of a granted cycle (pointer is 2 here).
    @(posedge clk);
    #1 drive(4'b0010, 4'b0000, {24'h0, 12'h020, 12'h0}, 48'h0);
    #3 chk("midrst grant", 64'(req_ready), 64'h2);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst ready in reset", 64'(req_ready), 64'h0);
    chk("midrst mem_write in reset", 64'(mem_write), 64'h0);
    @(posedge clk);
    #1;
    chk("midrst resp_valid in reset", 64'(resp_valid), 64'h0);
    reset_n = 1'b1;
    // Clients 0 and 3 store to the same address; pointer 0 makes client 0 win.
    drive(4'b1001, 4'b1001, {12'h060, 24'h0, 12'h060}, {12'h0BB, 24'h0, 12'h0AA});
    #3;
    chk("postrst resp_valid", 64'(resp_valid), 64'h0);
    chk("postrst tie winner", 64'(req_ready), 64'h1);
    chk("postrst mem_datain", 64'(mem_datain), {40'h0, 24'h0000AA});
    @(posedge clk);
    #1 drive(4'b1000, 4'b1000, {12'h060, 36'h0}, {12'h0BB, 36'h0});
    #3;
    chk_resp("postrst c0", 4'b0001, 4'b0001, {36'h0, 12'h0AA});
    chk("postrst c3 ready", 64'(req_ready), 64'h8);
    @(posedge clk);
    #1 drive(4'b0000, 4'b0000, 48'h0, 48'h0);
    #3 chk_resp("postrst c3", 4'b1000, 4'b1000, {12'h0BB, 36'h0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_arbiter.md
# mem_access_arbiter

Front-end request scheduler feeding the multiport dynamic RAM. Accepts load/store requests from `req_count` clients over valid/ready handshakes, grants up to `port_count` of them per cycle with round-robin fairness, drives the RAM's packed address/datain/mem_write buses, and routes the RAM's registered read data back to the originating client one cycle later. It also prevents same-address hazards between RAM ports so the RAM's port-order-dependent behaviour is never exercised.

## Interface
- `req_count`, 4, number of clients (2..8)
- `port_count`, 2, RAM ports driven; must match the RAM instance
- `mem_width`, 12, data word width
- `addr_width`, 12, address width
- `clk` in 1, rising-edge clock shared with the RAM
- `reset_n` in 1, asynchronous active-low reset (one clock; reset asynchronous, active-low)
- `req_valid` in `req_count`, client i has a request
- `req_ready` out `req_count`, client i granted this cycle
- `req_write` in `req_count`, 1 = store, 0 = load
- `req_addr` in `req_count*addr_width`, packed, client i at slice `[(i+1)*addr_width-1 -: addr_width]`
- `req_wdata` in `req_count*mem_width`, packed store data, same slicing
- `resp_valid` out `req_count`, one-cycle pulse per completed request
- `resp_data` out `req_count*mem_width`, packed response data
- `mem_address` out `port_count*addr_width`, to RAM `address`
- `mem_datain` out `port_count*mem_width`, to RAM `datain`
- `mem_write` out `port_count`, to RAM `mem_write`
- `mem_dataout` in `port_count*mem_width`, from RAM `dataout`

## Operation
- Handshake: request transfers when `req_valid[i] && req_ready[i]`. `req_ready` is combinational from `req_valid`, addresses and the priority pointer. Client must hold valid/write/addr/wdata stable until accepted.
- Selection: scan clients starting at pointer `rr_ptr`, wrapping modulo `req_count`; take up to `port_count` valid requests. k-th selected client drives port k.
- Conflict rule: a candidate is skipped (stays pending, ready=0) if its address equals an already-selected address this cycle and either access is a write. Reads to the same address may share a cycle.
- Pointer update: if any grant, `rr_ptr` <= (index of last granted client + 1) mod `req_count`; else unchanged.
- Unused ports: `mem_write`=0, `mem_address`=0, `mem_datain`=0.
- Tag pipeline: per port, register `{tag_valid, client_id}` on each grant. Next cycle, for each valid tag, `resp_valid[client_id]`=1 and `resp_data[client_id]` = that port's `mem_dataout` slice.
- Stores also respond; data is the written word (RAM is write-first).
- No response backpressure; clients always accept. At most one grant per client per cycle, so no response collisions.
- `resp_data` slices hold their last value when `resp_valid` is low.

## Timing
- Grant in cycle N (combinational ready) -> RAM samples at edge ending N -> `resp_valid` high throughout cycle N+1. Latency 1 cycle; throughput `port_count` requests/cycle.
- Back-to-back: client may be granted every cycle; store at N then load same address at N+1 returns new data at N+2.
- Reset (async, `reset_n`=0): `rr_ptr`=0, all tags invalid, `resp_valid`=0, `resp_data`=0; `req_ready`=0 and `mem_write`=0 while in reset. Reset mid-operation drops in-flight responses; no response after release for pre-reset grants.
- First grant possible in the first cycle with `reset_n`=1.
- Top level ties the RAM's active-high `reset` to `~reset_n`.

## Structure
- Shared package `mem_pkg`: default `mem_width`, `addr_width`, `port_count`, and a `clog2` function for `client_id` width.
- Sub-module `rr_grant_select`: combinational rotate-priority picker with conflict masking, producing per-port client index/valid and the `req_ready` vector. Top level holds the pointer, tag registers, bus packing, and response routing.

## Test plan
- Single store: client 0 writes 0xABC to 0x010 at cycle 1 -> `req_ready[0]`=1 at cycle 1, `mem_write`=01, `resp_valid[0]` at cycle 2 with 0xABC.
- Store then load: client 1 stores 0x123 to 0x020 at cycle 1 and loads 0x020 at cycle 2 -> `resp_data[1]`=0x123 at cycle 3.
- Fairness: all 4 clients loading distinct addresses continuously -> grants {0,1},{2,3},{0,1}..., each client one response every 2 cycles.
- Write conflict: clients 0 and 1 store 0x111/0x222 to 0x040 same cycle, `rr_ptr`=0 -> client 0 granted, client 1 next cycle; subsequent load of 0x040 returns 0x222.
- Read sharing: clients 2 and 3 load 0x050 same cycle -> both granted; both responses equal the RAM contents next cycle.
- Reset mid-flight: grant at cycle 5, `reset_n` low in cycle 5 -> no `resp_valid` at cycle 6; after release `rr_ptr`=0 and client 0 wins ties.
